// File: rtl/ss_output_decoder_if.sv
// ss_output_decoder_if: stochastic sample stream in, window counts and classification out
interface ss_output_decoder_if #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int IW = 3
);
  logic                 EN;
  logic [N-1:0]         a_in;
  logic [IW-1:0]        label;
  logic [N*(W+1)-1:0]   counts;
  logic [IW-1:0]        class_out;
  logic [W:0]           max_count;
  logic                 correct;
  logic                 valid;
  logic                 busy;
  modport master (
    output EN, a_in, label,
    input  counts, class_out, max_count, correct, valid, busy
  );
  modport slave (
    input  EN, a_in, label,
    output counts, class_out, max_count, correct, valid, busy
  );
endinterface

// File: rtl/ss_output_decoder.sv
// ss_output_decoder: per-channel ones counting over 2^W samples, then sequential argmax
module ss_output_decoder #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int IW = 3
) (
  input logic CLK,
  input logic INIT,
  ss_output_decoder_if.slave bus
);
  typedef enum logic [1:0] {SCAN_IDLE, SCAN, REPORT} state_t;
  state_t        state, state_n;
  logic [W:0]    acc [N];
  logic [W:0]    cnt [N];
  logic [W-1:0]  wc;
  logic [IW-1:0] lbl_r, idx, best_idx;
  logic [W:0]    best_cnt;
  logic          capture;
  assign capture  = bus.EN && (wc == '1);
  assign bus.busy = state != SCAN_IDLE;
  for (genvar k = 0; k < N; k++) begin : g_pack
    assign bus.counts[k*(W+1) +: W+1] = cnt[k];
  end
  always_comb begin
    state_n = state;
    state_n = (state == SCAN_IDLE && capture)       ? SCAN      :
              (state == SCAN && idx == IW'(N - 1))  ? REPORT    :
              (state == REPORT)                     ? SCAN_IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state         <= SCAN_IDLE;
      acc           <= '{default: '0};
      cnt           <= '{default: '0};
      wc            <= '0;
      lbl_r         <= '0;
      idx           <= '0;
      best_idx      <= '0;
      best_cnt      <= '0;
      bus.class_out <= '0;
      bus.max_count <= '0;
      bus.correct   <= 1'b0;
      bus.valid     <= 1'b0;
    end else begin
      state     <= state_n;
      bus.valid <= state == REPORT;
      if (bus.EN) begin
        wc <= wc + W'(1);
        for (int k = 0; k < N; k++) acc[k] <= capture ? '0 : acc[k] + (W+1)'(bus.a_in[k]);
      end
      // the last sample of the window goes straight into the snapshot
      if (capture) begin
        for (int k = 0; k < N; k++) cnt[k] <= acc[k] + (W+1)'(bus.a_in[k]);
        lbl_r    <= bus.label;
        idx      <= '0;
        best_idx <= '0;
        best_cnt <= '0;
      end
      if (state == SCAN) begin
        if (cnt[idx] > best_cnt) begin
          best_idx <= idx;
          best_cnt <= cnt[idx];
        end
        idx <= idx + IW'(1);
      end
      if (state == REPORT) begin
        bus.class_out <= best_idx;
        bus.max_count <= best_cnt;
        bus.correct   <= best_idx == lbl_r;
      end
    end
  end
endmodule

// File: tb/tb_ss_output_decoder.sv
// tb_ss_output_decoder: directed windows with hand-computed counts, classes and pulse timing
module tb_ss_output_decoder;
  logic clk = 1'b0;
  logic init;
  int   vecs = 0;
  int   errs = 0;
  ss_output_decoder_if #(.N(5), .W(8), .IW(3)) bus ();
  ss_output_decoder #(.N(5), .W(8), .IW(3)) dut (.CLK(clk), .INIT(init), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [8:0] ch(input int k);
    return bus.counts[k*9 +: 9];
  endfunction
  task automatic feed(input logic [4:0] a, input logic [2:0] lbl, input bit toggle);
    for (int i = 0; i < 256; i++) begin
      if (toggle) begin
        bus.EN = 1'b0;
        bus.a_in = '1;
        step();
      end
      if (toggle && i == 255) check("pre_cap_busy", bus.busy, 0);
      bus.EN = 1'b1;
      bus.a_in = a;
      bus.label = lbl;
      step();
    end
    bus.EN = 1'b0;
    bus.a_in = '0;
    check("busy_cap", bus.busy, 1);
  endtask
  task automatic await_valid(output int lat);
    lat = 99;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (bus.valid) begin
        lat = j;
        break;
      end
    end
  endtask
  initial begin
    int lat, pulses, t1, t2;
    logic [2:0] c1, c2;
    init = 1'b1;
    bus.EN = 1'b0;
    bus.a_in = '0;
    bus.label = '0;
    repeat (3) step();
    init = 1'b0;
    check("rst_counts", bus.counts, 0);
    check("rst_class", bus.class_out, 0);
    check("rst_max", bus.max_count, 0);
    check("rst_correct", bus.correct, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    // single hot channel
    feed(5'b00100, 3'd2, 1'b0);
    await_valid(lat);
    check("t1_latency", lat, 6);
    check("t1_class", bus.class_out, 2);
    check("t1_max", bus.max_count, 256);
    check("t1_correct", bus.correct, 1);
    check("t1_ch2", ch(2), 256);
    check("t1_others", {ch(0), ch(1), ch(3), ch(4)}, 0);
    step();
    check("t1_pulse_width", bus.valid, 0);
    check("t1_idle", bus.busy, 0);
    // tie between 1 and 3
    feed(5'b01010, 3'd1, 1'b0);
    await_valid(lat);
    check("tie_latency", lat, 6);
    check("tie_class", bus.class_out, 1);
    check("tie_correct", bus.correct, 1);
    feed(5'b01010, 3'd3, 1'b0);
    await_valid(lat);
    check("tie3_class", bus.class_out, 1);
    check("tie3_correct", bus.correct, 0);
    check("tie3_max", bus.max_count, 256);
    // EN toggling, disabled samples carry all ones
    feed(5'b00001, 3'd0, 1'b1);
    await_valid(lat);
    check("tog_latency", lat, 6);
    check("tog_ch0", ch(0), 256);
    check("tog_ch1", ch(1), 0);
    check("tog_class", bus.class_out, 0);
    // back-to-back windows
    pulses = 0; t1 = 0; t2 = 0; c1 = '0; c2 = '0;
    for (int i = 0; i < 512; i++) begin
      bus.EN = 1'b1;
      bus.a_in = (i < 256) ? 5'b10000 : 5'b00001;
      bus.label = '0;
      step();
      if (i == 300) check("hold_a", {ch(4), ch(0)}, {9'd256, 9'd0});
      if (bus.valid) begin
        pulses++;
        if (pulses == 1) begin t1 = i + 1; c1 = bus.class_out; end
        else begin t2 = i + 1; c2 = bus.class_out; end
      end
    end
    bus.EN = 1'b0;
    bus.a_in = '0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (bus.valid) begin
        pulses++;
        if (pulses == 1) begin t1 = 513 + j; c1 = bus.class_out; end
        else begin t2 = 513 + j; c2 = bus.class_out; end
      end
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_first_edge", t1, 262);
    check("b2b_spacing", t2 - t1, 256);
    check("b2b_class_a", c1, 4);
    check("b2b_class_b", c2, 0);
    check("b2b_counts_b", {ch(4), ch(0)}, {9'd0, 9'd256});
    check("b2b_correct", bus.correct, 1);
    // INIT on the third scan edge
    feed(5'b01000, 3'd3, 1'b0);
    step();
    step();
    init = 1'b1;
    step();
    init = 1'b0;
    check("abort_counts", bus.counts, 0);
    check("abort_class", bus.class_out, 0);
    check("abort_max", bus.max_count, 0);
    check("abort_correct", bus.correct, 0);
    check("abort_busy", bus.busy, 0);
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.valid) pulses++;
      step();
    end
    check("abort_no_valid", pulses, 0);
    feed(5'b01000, 3'd3, 1'b0);
    await_valid(lat);
    check("post_abort_latency", lat, 6);
    check("post_abort_class", bus.class_out, 3);
    check("post_abort_max", bus.max_count, 256);
    check("post_abort_correct", bus.correct, 1);
    // all-zero window
    feed(5'b00000, 3'd0, 1'b0);
    await_valid(lat);
    check("zero_latency", lat, 6);
    check("zero_class", bus.class_out, 0);
    check("zero_max", bus.max_count, 0);
    check("zero_counts", bus.counts, 0);
    check("zero_correct", bus.correct, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ss_output_decoder.md
Name: ss_output_decoder

Overview:
- Sits directly downstream of the fully connected layer-3 block and consumes its N-bit stochastic output stream (a_out).
- Counts ones per output node over a fixed window of 2^W enabled cycles, then snapshots the counts.
- Runs a sequential argmax over the snapshot to produce a classification, its count, and a correct flag against a target label.
- Accumulation continues into the next window while the scan of the current snapshot runs, so there is no dead time between windows.

Parameters:
- N, 5, number of stochastic input channels (layer-3 nodes).
- W, 8, log2 of window length; window = 2^W enabled samples.
- IW, 3, width of class index and label; must satisfy 2^IW >= N.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- INIT  input  1  synchronous active-high reset.
- EN  input  1  sample-valid; a_in is counted only on cycles with EN=1.
- a_in  input  N  stochastic bitstreams, bit k = node k.
- label  input  IW  target class index; sampled on the capture edge.
- counts  output  N*(W+1)  snapshot counts; channel k at bits [k*(W+1) +: W+1].
- class_out  output  IW  argmax channel index of the last completed window.
- max_count  output  W+1  count of class_out.
- correct  output  1  class_out == sampled label.
- valid  output  1  one-cycle pulse when class_out/max_count/correct update.
- busy  output  1  high while the scan is in progress.

Behaviour:
- Reset, with INIT=1 at an edge:
  - accumulators, window counter, counts, class_out, max_count, correct and valid all go to 0.
  - busy goes to 0 and the FSM enters SCAN_IDLE.
  - INIT takes priority over every other event.
- Accumulation (always active, independent of scan state):
  - On an edge with EN=1, acc[k] += a_in[k] and the window counter wc (W bits) increments.
  - EN=0 freezes acc and wc.
- Capture:
  - Occurs on an edge with EN=1 and wc == 2^W-1.
  - counts[k] <= acc[k] + a_in[k], so the final sample is included; maximum 2^W, hence W+1 bits.
  - acc[k] <= 0, wc <= 0 (wraps), label latched to lbl_r, and the scan starts.
- Scan FSM, states SCAN_IDLE, SCAN, REPORT:
  - SCAN_IDLE -> SCAN on the capture edge; idx <= 0, best_idx <= 0, best_cnt <= 0.
  - SCAN, one channel per edge: if counts[idx] > best_cnt (strict), then best_idx <= idx and best_cnt <= counts[idx]. idx increments. After the edge that processes idx == N-1, go to REPORT.
  - REPORT, one edge:
    - class_out <= best_idx, max_count <= best_cnt, correct <= (best_idx == lbl_r), valid <= 1.
    - Return to SCAN_IDLE.
  - busy = 1 in SCAN and REPORT.
- Latency and pulse rules:
  - valid is high for exactly one cycle, beginning N+1 edges after the capture edge (edge N+1 counting the capture edge as edge 0).
  - valid is 0 on all other cycles.
- Ties: strict compare, so the lowest index wins. An all-zero window reports class 0 with max_count 0.
- Windows must exceed the scan: 2^W >= N+2 is required, so a new capture never arrives during SCAN/REPORT. A capture arriving while busy is a configuration error and is not handled.
- Held outputs:
  - counts holds its value from capture until the next capture.
  - class_out, max_count and correct hold their values until the next REPORT.
- INIT mid-scan aborts the scan: no valid is produced, and all outputs return to reset values.
- Overflow: none possible; acc max = 2^W fits in W+1 bits.

Test Plan:
- Only channel 2 held at 1 with EN=1 for 256 cycles (W=8):
  - counts ch2 = 256, others = 0.
  - valid pulses once, 6 edges after capture.
  - class_out = 2, max_count = 256.
- Channels 1 and 3 both held at 1, label=1:
  - tie resolves to class_out = 1, correct = 1.
  - repeat with label = 3 -> correct = 0.
- EN toggled 1/0 every cycle, ch0 = 1:
  - capture occurs after 512 clocks (256 enabled samples).
  - ch0 count = 256; bits presented with EN=0 are not counted.
- Back-to-back windows: window A ch4 all ones, window B ch0 all ones:
  - two valid pulses exactly 256 clocks apart, class_out 4 then 0.
  - counts of window B are unaffected by the scan of A.
- Assert INIT during SCAN (third scan edge):
  - no valid pulse; all outputs 0 on the next cycle.
  - the next full window reports normally.
- All-zero input for one window -> valid pulse with class_out = 0, max_count = 0, counts all 0.
